write_to_fifo_block: RTL and testbench

WRITE_TO_FIFO_BLOCK -- requirements
Module: write_to_fifo

---
 rtl/write_to_fifo_block_pkg.sv | 36 +++
 rtl/write_to_fifo_block_fifo_16x16.sv | 63 ++++++
 rtl/write_to_fifo_block.sv | 189 ++++++++++++++++++
 tb/tb_write_to_fifo_block.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/write_to_fifo_block_pkg.sv
// Shared constants, state encoding and helpers for write_to_fifo_block.
// Address map, last-word flag, FIFO depth and 128-bit word selector.
package write_to_fifo_block_pkg;

    localparam logic [31:0] ADDR_HELLO = 32'h0000_0500;
    localparam logic [31:0] ADDR_VLED  = 32'h0000_0504;
    localparam logic [31:0] ADDR_FIFO  = 32'h0000_0510;
    localparam logic [31:0] ADDR_KEY   = 32'h0000_0520;
    localparam logic [31:0] ADDR_DIN   = 32'h0000_0530;
    localparam logic [31:0] ADDR_RES   = 32'h0000_0540;

    localparam logic [15:0] LAST_FLAG  = 16'h1111;
    localparam int          FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Word 0 is the most-significant 32 bits.
    function automatic logic [31:0] word_sel(
        input logic [127:0] v,
        input logic [1:0]   idx
    );
        logic [31:0] w;
        unique case (idx)
            2'd0:    w = v[127:96];
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/write_to_fifo_block_fifo_16x16.sv
// Circular 16x16 FIFO; a push when full drops the oldest entry.
// Ports: clk, rst_n, push, pop, clr, din, dout (head), count, full, empty.
module fifo_16x16
    import write_to_fifo_block_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty
);

    logic [15:0] mem [FIFO_DEPTH];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [3:0]  wr_idx;
    logic        do_pop;
    logic        drop;

    assign full   = (count == 5'(FIFO_DEPTH));
    assign empty  = (count == 5'd0);
    assign dout   = mem[rd_ptr];
    // Clear with push restarts the ring at slot 0.
    assign wr_idx = clr ? 4'd0 : wr_ptr;
    assign do_pop = pop && !empty;
    assign drop   = push && !do_pop && full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
            count  <= 5'd0;
        end else if (clr) begin
            rd_ptr <= 4'd0;
            wr_ptr <= push ? 4'd1 : 4'd0;
            count  <= push ? 5'd1 : 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (do_pop || drop) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
            if (push && !do_pop && !full) begin
                count <= count + 5'd1;
            end else if (do_pop && !push) begin
                count <= count - 5'd1;
            end
        end
    end

endmodule

// File: rtl/write_to_fifo_block.sv
// Collects 16 key/data byte pairs, drains them into 128-bit key/din
// registers and forms key^din. Ports: clk/reset, write strobe bus,
// AXI-lite style read channel, vled_q status in, hello_world_q out.
module write_to_fifo_block
    import write_to_fifo_block_pkg::*;
(
    input  logic        clk_main_a0,
    input  logic        rst_main_n_sync,
    input  logic [31:0] wr_addr,
    input  logic        wready,
    input  logic [31:0] wdata,
    input  logic        rready,
    input  logic        arvalid_q,
    input  logic [31:0] araddr_q,
    input  logic [15:0] vled_q,
    output logic [1:0]  rresp,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [31:0] hello_world_q
);

    state_t       state;
    logic [3:0]   pop_cnt;
    logic [127:0] key_reg;
    logic [127:0] din_reg;
    logic [127:0] result_reg;
    logic         done;
    logic         short_err;

    logic         f_push;
    logic         f_pop;
    logic         f_clr;
    logic [15:0]  f_dout;
    logic [4:0]   f_count;
    logic         f_full;
    logic         f_empty;

    logic         wr_fifo;
    logic         flag;
    logic [4:0]   cnt_after;
    logic         short_hit;
    logic [127:0] key_next;
    logic [127:0] din_next;
    logic [31:0]  status;
    logic [31:0]  rd_word;
    logic [31:0]  rd_base;
    logic         rd_aligned;

    assign rresp = 2'b00;

    fifo_16x16 u_fifo (
        .clk   (clk_main_a0),
        .rst_n (rst_main_n_sync),
        .push  (f_push),
        .pop   (f_pop),
        .clr   (f_clr),
        .din   (wdata[15:0]),
        .dout  (f_dout),
        .count (f_count),
        .full  (f_full),
        .empty (f_empty)
    );

    assign wr_fifo   = wready && (wr_addr == ADDR_FIFO);
    assign flag      = (wdata[31:16] == LAST_FLAG);
    assign cnt_after = f_full ? f_count : f_count + 5'd1;
    assign key_next  = {key_reg[119:0], f_dout[15:8]};
    assign din_next  = {din_reg[119:0], f_dout[7:0]};

    always_comb begin
        f_push    = 1'b0;
        f_pop     = 1'b0;
        f_clr     = 1'b0;
        short_hit = 1'b0;
        unique case (state)
            ST_FILL: begin
                if (wr_fifo) begin
                    // A short flag word is dropped with the rest.
                    if (flag && cnt_after != 5'(FIFO_DEPTH)) begin
                        f_clr     = 1'b1;
                        short_hit = 1'b1;
                    end else begin
                        f_push = 1'b1;
                    end
                end
            end
            ST_DRAIN: f_pop = 1'b1;
            ST_DONE: begin
                if (wr_fifo && !flag) begin
                    f_clr  = 1'b1;
                    f_push = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            state      <= ST_FILL;
            pop_cnt    <= 4'd0;
            key_reg    <= '0;
            din_reg    <= '0;
            result_reg <= '0;
            done       <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            unique case (state)
                ST_FILL: begin
                    if (short_hit) begin
                        short_err <= 1'b1;
                    end else if (wr_fifo && flag) begin
                        state   <= ST_DRAIN;
                        pop_cnt <= 4'd0;
                    end
                end
                ST_DRAIN: begin
                    key_reg <= key_next;
                    din_reg <= din_next;
                    pop_cnt <= pop_cnt + 4'd1;
                    if (pop_cnt == 4'd15) begin
                        state      <= ST_DONE;
                        result_reg <= key_next ^ din_next;
                        done       <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (wr_fifo && !flag) begin
                        done      <= 1'b0;
                        short_err <= 1'b0;
                        state     <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            hello_world_q <= 32'h0;
        end else if (wready && wr_addr == ADDR_HELLO) begin
            hello_world_q <= wdata;
        end
    end

    assign status = {23'h0, f_count, 1'b0, short_err,
                     (state == ST_DRAIN), done};

    assign rd_base    = {araddr_q[31:4], 4'h0};
    assign rd_aligned = (araddr_q[1:0] == 2'b00);

    always_comb begin
        rd_word = 32'h0;
        unique case (1'b1)
            araddr_q == ADDR_HELLO:
                rd_word = hello_world_q;
            araddr_q == ADDR_VLED:
                rd_word = {16'h0, vled_q};
            araddr_q == ADDR_FIFO:
                rd_word = status;
            rd_aligned && rd_base == ADDR_KEY:
                rd_word = word_sel(key_reg, araddr_q[3:2]);
            rd_aligned && rd_base == ADDR_DIN:
                rd_word = word_sel(din_reg, araddr_q[3:2]);
            rd_aligned && rd_base == ADDR_RES:
                rd_word = word_sel(result_reg, araddr_q[3:2]);
            default:
                rd_word = 32'h0;
        endcase
    end

    // Data is captured at address acceptance, so a same-cycle
    // write is not visible in this read.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0;
        end else if (!rvalid) begin
            if (arvalid_q) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
            end
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_to_fifo_block.sv
// Directed self-checking bench for write_to_fifo_block.
// Drives on negedge, samples on negedge.
module tb_write_to_fifo_block;

    logic        clk_main_a0;
    logic        rst_main_n_sync;
    logic [31:0] wr_addr;
    logic        wready;
    logic [31:0] wdata;
    logic        rready;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic [15:0] vled_q;
    logic [1:0]  rresp;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] hello_world_q;

    int checks = 0;
    int errors = 0;

    write_to_fifo_block dut (
        .clk_main_a0     (clk_main_a0),
        .rst_main_n_sync (rst_main_n_sync),
        .wr_addr         (wr_addr),
        .wready          (wready),
        .wdata           (wdata),
        .rready          (rready),
        .arvalid_q       (arvalid_q),
        .araddr_q        (araddr_q),
        .vled_q          (vled_q),
        .rresp           (rresp),
        .rvalid          (rvalid),
        .rdata           (rdata),
        .hello_world_q   (hello_world_q)
    );

    initial clk_main_a0 = 1'b0;
    always #5 clk_main_a0 = ~clk_main_a0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at the next negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wready  = 1'b1;
        wr_addr = a;
        wdata   = d;
        @(negedge clk_main_a0);
        wready  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        int n;
        arvalid_q = 1'b1;
        araddr_q  = a;
        @(negedge clk_main_a0);
        arvalid_q = 1'b0;
        n = 0;
        while (!rvalid && n < 8) begin
            @(negedge clk_main_a0);
            n++;
        end
        if (!rvalid) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout got 0 exp 1");
        end
        d = rdata;
        rready = 1'b1;
        @(negedge clk_main_a0);
        rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic pair(input logic [15:0] f, input logic [7:0] k,
                        input logic [7:0] v);
        wr(32'h510, {f, k, v});
    endtask

    logic [31:0] d;

    initial begin
        rst_main_n_sync = 1'b0;
        wr_addr   = 32'h0;
        wready    = 1'b0;
        wdata     = 32'h0;
        rready    = 1'b0;
        arvalid_q = 1'b0;
        araddr_q  = 32'h0;
        vled_q    = 16'hA5C3;
        repeat (2) @(negedge clk_main_a0);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_hello", hello_world_q, 32'h0);
        check("rst_rresp", {30'h0, rresp}, 32'h0);
        rst_main_n_sync = 1'b1;
        @(negedge clk_main_a0);

        rd_chk("status_rst", 32'h510, 32'h0);
        rd_chk("vled", 32'h504, 32'h0000A5C3);
        rd_chk("unmapped", 32'h514, 32'h0);
        rd_chk("unaligned", 32'h522, 32'h0);

        // Held read handshake.
        wr(32'h500, 32'hCAFEF00D);
        check("hello_q", hello_world_q, 32'hCAFEF00D);
        arvalid_q = 1'b1;
        araddr_q  = 32'h500;
        @(negedge clk_main_a0);
        arvalid_q = 1'b0;
        repeat (2) @(negedge clk_main_a0);
        check("hold_rvalid", {31'h0, rvalid}, 32'h1);
        check("hold_rdata", rdata, 32'hCAFEF00D);
        check("hold_rresp", {30'h0, rresp}, 32'h0);
        rready = 1'b1;
        @(negedge clk_main_a0);
        rready = 1'b0;
        check("rvalid_clr", {31'h0, rvalid}, 32'h0);

        // Simultaneous write and read returns the old value.
        wready    = 1'b1;
        wr_addr   = 32'h500;
        wdata     = 32'h12345678;
        arvalid_q = 1'b1;
        araddr_q  = 32'h500;
        @(negedge clk_main_a0);
        wready    = 1'b0;
        arvalid_q = 1'b0;
        check("rw_old", rdata, 32'hCAFEF00D);
        check("rw_new", hello_world_q, 32'h12345678);
        rready = 1'b1;
        @(negedge clk_main_a0);
        rready = 1'b0;

        // Full fill: key i, data 0x11*i.
        for (int i = 0; i < 15; i++) begin
            pair(16'h0, 8'(i), 8'(i * 17));
        end
        pair(16'h1111, 8'h0f, 8'hff);
        rd_chk("status_drain", 32'h510, 32'h102);
        repeat (14) @(negedge clk_main_a0);
        rd_chk("status_done", 32'h510, 32'h1);
        rd_chk("key0", 32'h520, 32'h00010203);
        rd_chk("key1", 32'h524, 32'h04050607);
        rd_chk("key2", 32'h528, 32'h08090a0b);
        rd_chk("key3", 32'h52C, 32'h0c0d0e0f);
        rd_chk("din0", 32'h530, 32'h00112233);
        rd_chk("din1", 32'h534, 32'h44556677);
        rd_chk("din2", 32'h538, 32'h8899aabb);
        rd_chk("din3", 32'h53C, 32'hccddeeff);
        rd_chk("res0", 32'h540, 32'h00102030);
        rd_chk("res1", 32'h544, 32'h40506070);
        rd_chk("res2", 32'h548, 32'h8090a0b0);
        rd_chk("res3", 32'h54C, 32'hc0d0e0f0);

        // Held flag writes in DONE are ignored.
        wready  = 1'b1;
        wr_addr = 32'h510;
        wdata   = 32'h1111_AA55;
        repeat (4) @(negedge clk_main_a0);
        wready  = 1'b0;
        rd_chk("flag_ign_st", 32'h510, 32'h1);
        rd_chk("flag_ign_res", 32'h540, 32'h00102030);

        // Exit DONE with one pair, 4 more, then a short flag.
        pair(16'h0, 8'h01, 8'h02);
        rd_chk("done_exit", 32'h510, 32'h10);
        for (int i = 0; i < 4; i++) begin
            pair(16'h0, 8'(i), 8'(i));
        end
        pair(16'h1111, 8'h09, 8'h09);
        rd_chk("short_err", 32'h510, 32'h4);

        // 20 pairs then flag: key i, data 0x80+i; keep i=5..20.
        for (int i = 0; i < 20; i++) begin
            pair(16'h0, 8'(i), 8'(8'h80 + i));
        end
        pair(16'h1111, 8'd20, 8'h94);
        repeat (16) @(negedge clk_main_a0);
        rd(32'h510, d);
        check("ovf_done", {31'h0, d[0]}, 32'h1);
        rd_chk("ovf_key0", 32'h520, 32'h05060708);
        rd_chk("ovf_key3", 32'h52C, 32'h11121314);
        rd_chk("ovf_din0", 32'h530, 32'h85868788);
        rd_chk("ovf_din3", 32'h53C, 32'h91929394);
        rd_chk("ovf_res1", 32'h544, 32'h80808080);

        // Reset mid-drain with a read outstanding.
        for (int i = 0; i < 15; i++) begin
            pair(16'h0, 8'h33, 8'h44);
        end
        pair(16'h1111, 8'h33, 8'h44);
        arvalid_q = 1'b1;
        araddr_q  = 32'h500;
        @(negedge clk_main_a0);
        arvalid_q = 1'b0;
        check("mid_rvalid", {31'h0, rvalid}, 32'h1);
        rst_main_n_sync = 1'b0;
        #1;
        check("ar_rvalid", {31'h0, rvalid}, 32'h0);
        check("ar_rdata", rdata, 32'h0);
        check("ar_hello", hello_world_q, 32'h0);
        @(negedge clk_main_a0);
        rst_main_n_sync = 1'b1;
        @(negedge clk_main_a0);
        rd_chk("ar_status", 32'h510, 32'h0);
        rd_chk("ar_key0", 32'h520, 32'h0);
        rd_chk("ar_res0", 32'h540, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
